// File: rtl/cfix_accum_pkg.sv
// Shared utility types and helpers for the fixed-point datapath blocks.
// Holds FSM state encodings, FPU opcodes and signed saturation bounds.
package cfix_accum_pkg;

  typedef enum logic [1:0] {
    FPU_ADD,
    FPU_SUB,
    FPU_MUL,
    FPU_FMA
  } fpu_op_t;

  typedef enum logic {
    ST_ACC,
    ST_HOLD
  } acc_state_t;

  // Bounds of a signed word with n_tot magnitude bits plus sign.
  function automatic longint sat_max(input int n_tot);
    return (longint'(1) <<< n_tot) - longint'(1);
  endfunction

  function automatic longint sat_min(input int n_tot);
    return -(longint'(1) <<< n_tot);
  endfunction

endpackage

// File: rtl/fix_sat_add.sv
// Combinational signed saturating adder; zero latency, no flow control.
// Flags sat whenever the true sum falls outside the signed [N_TOT:0] range.
module fix_sat_add #(
  parameter int N_TOT = 31
) (
  input  logic signed [N_TOT:0] a,
  input  logic signed [N_TOT:0] b,
  output logic signed [N_TOT:0] sum,
  output logic                  sat
);
  import cfix_accum_pkg::*;

  localparam logic signed [N_TOT+1:0] SMAX = (N_TOT+2)'(sat_max(N_TOT));
  localparam logic signed [N_TOT+1:0] SMIN = (N_TOT+2)'(sat_min(N_TOT));

  logic signed [N_TOT+1:0] wide;

  always_comb begin
    wide = (N_TOT+2)'(a) + (N_TOT+2)'(b);
    sum  = wide[N_TOT:0];
    sat  = 1'b0;
    if (wide > SMAX) begin
      sum = SMAX[N_TOT:0];
      sat = 1'b1;
    end else if (wide < SMIN) begin
      sum = SMIN[N_TOT:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/cfix_accum.sv
// Complex saturating frame accumulator: sums N_ACC accepted samples per frame.
// Result valid 1 cycle after the last accept; held until out_ready, with same-cycle hand-off.
module cfix_accum #(
  parameter int n_int  = 8,
  parameter int n_mant = 23,
  parameter int N_ACC  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [n_int+n_mant:0]  inR,
  input  logic signed [n_int+n_mant:0]  inI,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [n_int+n_mant:0]  resultR,
  output logic signed [n_int+n_mant:0]  resultI,
  output logic                          ovf
);
  import cfix_accum_pkg::*;

  localparam int N_TOT = n_int + n_mant;
  localparam int CW    = (N_ACC > 1) ? $clog2(N_ACC) : 1;

  acc_state_t            state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic signed [N_TOT:0] acc_r, acc_i, acc_r_nxt, acc_i_nxt;
  logic signed [N_TOT:0] sum_r, sum_i, new_r, new_i;
  logic signed [N_TOT:0] res_r_nxt, res_i_nxt;
  logic                  sat_r, sat_i, flag, flag_nxt, new_flag;
  logic                  out_valid_nxt, ovf_nxt;
  logic                  accept, first, last;

  assign in_ready = !rst || (state == ST_ACC) || out_ready;
  assign accept   = rst && in_valid && in_ready && !clr;
  assign first    = (cnt == '0);
  assign last     = (cnt == CW'(N_ACC - 1));

  fix_sat_add #(.N_TOT(N_TOT)) u_add_r (.a(acc_r), .b(inR), .sum(sum_r), .sat(sat_r));
  fix_sat_add #(.N_TOT(N_TOT)) u_add_i (.a(acc_i), .b(inI), .sum(sum_i), .sat(sat_i));

  // First sample of a frame loads directly, so a stale accumulator never leaks in.
  assign new_r    = first ? inR : sum_r;
  assign new_i    = first ? inI : sum_i;
  assign new_flag = first ? 1'b0 : (flag | sat_r | sat_i);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    acc_r_nxt     = acc_r;
    acc_i_nxt     = acc_i;
    flag_nxt      = flag;
    out_valid_nxt = out_valid;
    res_r_nxt     = resultR;
    res_i_nxt     = resultI;
    ovf_nxt       = ovf;
    if (clr) begin
      state_nxt     = ST_ACC;
      cnt_nxt       = '0;
      acc_r_nxt     = '0;
      acc_i_nxt     = '0;
      flag_nxt      = 1'b0;
      out_valid_nxt = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid_nxt = 1'b0;
        state_nxt     = ST_ACC;
      end
      if (accept) begin
        acc_r_nxt = new_r;
        acc_i_nxt = new_i;
        flag_nxt  = new_flag;
        if (last) begin
          cnt_nxt       = '0;
          res_r_nxt     = new_r;
          res_i_nxt     = new_i;
          ovf_nxt       = new_flag;
          out_valid_nxt = 1'b1;
          state_nxt     = ST_HOLD;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_ACC;
      cnt       <= '0;
      acc_r     <= '0;
      acc_i     <= '0;
      flag      <= 1'b0;
      out_valid <= 1'b0;
      resultR   <= '0;
      resultI   <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      acc_r     <= acc_r_nxt;
      acc_i     <= acc_i_nxt;
      flag      <= flag_nxt;
      out_valid <= out_valid_nxt;
      resultR   <= res_r_nxt;
      resultI   <= res_i_nxt;
      ovf       <= ovf_nxt;
    end
  end

endmodule
